updown_count_seq_ctrl: RTL and testbench

- Sequencer that owns and drives an N-bit up/down count datapath.
- Accepts a scan configuration over a valid/ready handshake: low bound, high bound, mode and repeat count.
- On start, steps the count one value per clock through up, down or ping-pong scans, then reports completion.
- Sits between a host/CSR side and consumers of the count value (address scan, PWM/triangle generation, timers).

---
 rtl/updown_count_seq_ctrl_if.sv | 26 ++
 rtl/updown_count_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_updown_count_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_count_seq_ctrl_if.sv
// Scan configuration channel for updown_count_seq_ctrl.
// Host drives valid/fields; controller answers ready/err.
interface updown_count_seq_ctrl_if #(
  parameter int N = 4,
  parameter int R = 8
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_mode;
  logic [N-1:0] cfg_lo;
  logic [N-1:0] cfg_hi;
  logic [R-1:0] cfg_reps;
  logic         cfg_err;

  modport master (
    output cfg_valid, cfg_mode,
    output cfg_lo, cfg_hi, cfg_reps,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_mode,
    input  cfg_lo, cfg_hi, cfg_reps,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/updown_count_seq_ctrl.sv
// Up/down/ping-pong scan sequencer owning an N-bit count.
// Config via valid/ready, start/abort control, done pulse.
module updown_count_seq_ctrl #(
  parameter int N = 4,
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst,
  updown_count_seq_ctrl_if.slave cfg,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         dir,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] count_n;
  logic         dir_n;
  logic [N-1:0] lo_q, lo_n;
  logic [N-1:0] hi_q, hi_n;
  logic [1:0]   mode_q, mode_n;
  logic [R-1:0] reps_q, reps_n;
  logic [R-1:0] rep_q, rep_n;
  logic [R-1:0] rep_inc;
  logic         err_q, err_n;
  logic         xfer;
  logic         bad;
  logic         hit;

  assign cfg.cfg_ready = (state == IDLE) ||
                         (state == ARMED);
  assign cfg.cfg_err   = err_q;

  assign xfer = cfg.cfg_valid && cfg.cfg_ready;
  assign bad  = (cfg.cfg_lo > cfg.cfg_hi) ||
                (cfg.cfg_mode == 2'd3);

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign rep_inc = rep_q + 1'b1;

  // ping-pong is only terminal on the way down,
  // unless the range collapses to one value
  always_comb begin
    unique case (mode_q)
      2'd1:    hit = (count == lo_q);
      2'd2:    hit = (count == lo_q) &&
                     (dir || (lo_q == hi_q));
      default: hit = (count == hi_q);
    endcase
  end

  assign tc = busy && hit;

  always_comb begin
    state_n = state;
    count_n = count;
    dir_n   = dir;
    lo_n    = lo_q;
    hi_n    = hi_q;
    mode_n  = mode_q;
    reps_n  = reps_q;
    rep_n   = rep_q;
    err_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, ARMED: begin
          if (xfer && bad) begin
            err_n = 1'b1;
          end else if (xfer) begin
            lo_n    = cfg.cfg_lo;
            hi_n    = cfg.cfg_hi;
            mode_n  = cfg.cfg_mode;
            reps_n  = cfg.cfg_reps;
            rep_n   = '0;
            state_n = ARMED;
            dir_n   = (cfg.cfg_mode == 2'd1);
            count_n = (cfg.cfg_mode == 2'd1) ?
                      cfg.cfg_hi : cfg.cfg_lo;
          end
          if (state == ARMED && start)
            state_n = RUN;
        end
        RUN: begin
          if (tc) begin
            rep_n = rep_inc;
            if (reps_q != '0 && rep_inc == reps_q) begin
              state_n = DONE;
            end else begin
              unique case (mode_q)
                2'd1: count_n = hi_q;
                2'd2: begin
                  dir_n   = 1'b0;
                  count_n = (lo_q == hi_q) ?
                            lo_q : lo_q + 1'b1;
                end
                default: count_n = lo_q;
              endcase
            end
          end else begin
            unique case (mode_q)
              2'd1: count_n = count - 1'b1;
              2'd2: begin
                if (dir) begin
                  count_n = count - 1'b1;
                end else if (count == hi_q) begin
                  dir_n   = 1'b1;
                  count_n = hi_q - 1'b1;
                end else begin
                  count_n = count + 1'b1;
                end
              end
              default: count_n = count + 1'b1;
            endcase
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      dir    <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      mode_q <= '0;
      reps_q <= '0;
      rep_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      dir    <= dir_n;
      lo_q   <= lo_n;
      hi_q   <= hi_n;
      mode_q <= mode_n;
      reps_q <= reps_n;
      rep_q  <= rep_n;
      err_q  <= err_n;
    end
  end

endmodule

// File: tb/tb_updown_count_seq_ctrl.sv
// Bench for updown_count_seq_ctrl: config table plus
// an expected-output queue fed by a scan-list model.
module tb_updown_count_seq_ctrl;

  localparam int N = 4;
  localparam int R = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] count;
  logic         dir, busy, tc, done;

  updown_count_seq_ctrl_if #(.N(N), .R(R)) cif ();

  updown_count_seq_ctrl #(.N(N), .R(R)) dut (
    .clk   (clk),
    .rst   (rst),
    .cfg   (cif.slave),
    .start (start),
    .abort (abort),
    .count (count),
    .dir   (dir),
    .busy  (busy),
    .tc    (tc),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int dir;
    int busy;
    int tc;
    int done;
  } exp_t;

  typedef struct {
    int mode;
    int lo;
    int hi;
    int reps;
    int err;
  } vec_t;

  exp_t q[$];
  vec_t vt[9];
  int   tests = 0;
  int   fails = 0;
  int   last_c;
  int   last_d;

  task automatic chk(input string nm,
                     input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int d,
                      input int b, input int t,
                      input int dn);
    exp_t e;
    e.count = c; e.dir = d; e.busy = b;
    e.tc = t; e.done = dn;
    q.push_back(e);
    last_c = c;
    last_d = d;
  endtask

  // scan-list model: one entry per expected cycle
  task automatic model(input int m, input int lo,
                       input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      if (m == 0) begin
        for (int v = lo; v <= hi; v++)
          push(v, 0, 1, int'(v == hi), 0);
      end else if (m == 1) begin
        for (int v = hi; v >= lo; v--)
          push(v, 1, 1, int'(v == lo), 0);
      end else if (lo == hi) begin
        push(lo, 0, 1, 1, 0);
      end else begin
        for (int v = (r == 0) ? lo : lo + 1;
             v <= hi; v++)
          push(v, 0, 1, 0, 0);
        for (int v = hi - 1; v >= lo; v--)
          push(v, 1, 1, int'(v == lo), 0);
      end
    end
    push(last_c, last_d, 0, 0, 1);
    push(last_c, last_d, 0, 0, 0);
  endtask

  task automatic drive_cfg(input int m, input int lo,
                           input int hi, input int reps);
    cif.cfg_valid = 1'b1;
    cif.cfg_mode  = 2'(m);
    cif.cfg_lo    = N'(lo);
    cif.cfg_hi    = N'(hi);
    cif.cfg_reps  = R'(reps);
  endtask

  task automatic drain(input string nm);
    exp_t e;
    int   k = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({nm, ".count"}, int'(count), e.count);
      chk({nm, ".dir"},   int'(dir),   e.dir);
      chk({nm, ".busy"},  int'(busy),  e.busy);
      chk({nm, ".tc"},    int'(tc),    e.tc);
      chk({nm, ".done"},  int'(done),  e.done);
      k++;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{0, 3, 6, 2, 0};
    vt[1] = '{2, 2, 5, 1, 0};
    vt[2] = '{1, 2, 9, 1, 0};
    vt[3] = '{0, 4, 4, 3, 0};
    vt[4] = '{2, 4, 4, 2, 0};
    vt[5] = '{2, 1, 3, 2, 0};
    vt[6] = '{0, 9, 4, 1, 1};
    vt[7] = '{3, 1, 2, 1, 1};
    vt[8] = '{1, 0, 15, 1, 0};

    cif.cfg_valid = 1'b0;
    drive_cfg(0, 0, 0, 0);
    cif.cfg_valid = 1'b0;
    #12;
    chk("rst.count", int'(count), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ready", int'(cif.cfg_ready), 1);
    chk("rst.err", int'(cif.cfg_err), 0);
    rst = 1'b0;
    cyc();

    foreach (vt[i]) begin
      drive_cfg(vt[i].mode, vt[i].lo,
                vt[i].hi, vt[i].reps);
      cyc();
      cif.cfg_valid = 1'b0;
      chk($sformatf("v%0d.err", i),
          int'(cif.cfg_err), vt[i].err);
      chk($sformatf("v%0d.ready", i),
          int'(cif.cfg_ready), 1);
      if (vt[i].err != 0) begin
        cyc();
        chk($sformatf("v%0d.errpulse", i),
            int'(cif.cfg_err), 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk($sformatf("v%0d.ign", i), int'(busy), 0);
      end else begin
        start = 1'b1;
        model(vt[i].mode, vt[i].lo,
              vt[i].hi, vt[i].reps);
        cyc();
        start = 1'b0;
        drain($sformatf("v%0d", i));
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk($sformatf("v%0d.restart", i),
            int'(busy), 0);
      end
    end

    // config replaced in ARMED on the same edge as start
    drive_cfg(0, 1, 2, 1);
    cyc();
    drive_cfg(1, 5, 8, 1);
    start = 1'b1;
    model(1, 5, 8, 1);
    cyc();
    cif.cfg_valid = 1'b0;
    start = 1'b0;
    drain("swap");

    // reps=0 keeps running; lo==hi makes tc constant
    drive_cfg(0, 7, 7, 0);
    cyc();
    cif.cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      n += int'(busy && tc && count == 4'd7);
      cyc();
    end
    chk("forever.run", n, 300);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("forever.abort", int'(busy), 0);

    // abort mid down-scan
    drive_cfg(1, 0, 15, 0);
    cyc();
    cif.cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (count != 4'd7 && n < 40) begin
      n++;
      cyc();
    end
    chk("abort.reach", n, 8);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.count", int'(count), 7);
    chk("abort.dir", int'(dir), 1);
    chk("abort.done", int'(done), 0);
    chk("abort.ready", int'(cif.cfg_ready), 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("abort.nostart", int'(busy), 0);
    chk("abort.nodone", int'(done), 0);

    // abort wins over config acceptance
    drive_cfg(0, 2, 9, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cif.cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("abort.cfg", int'(busy), 0);

    // asynchronous reset between edges
    drive_cfg(0, 2, 9, 1);
    cyc();
    cif.cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("arst.pre", int'(count), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.count", int'(count), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.dir", int'(dir), 0);
    chk("arst.tc", int'(tc), 0);
    chk("arst.done", int'(done), 0);
    chk("arst.ready", int'(cif.cfg_ready), 1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("arst.hold", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
